// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// Module   : reg_bank_arbiter
// Purpose  : Two-port round-robin arbiter and access sequencer in front of a
//            register bank application interface. Each accepted request is
//            captured, issued to the bank until it acknowledges, and its
//            response is returned to the requesting port with a one-cycle
//            done pulse.
// Ports    : clk, rst                - clock (rising edge), sync active-high reset
//            reqN_valid_i/wr_rdn_i/addr_i/wdata_i  - port N request (N = 0,1)
//            reqN_gnt_o              - port N request accepted (combinational)
//            reqN_done_o             - port N access complete (one-cycle pulse)
//            reqN_rdata_o/err_o      - port N response, held until next done
//            bank_ena_o/wr_rdn_o/addr_o/wdata_o/we_o - bank request side
//            bank_rdata_i/ack_i/err_i              - bank response side
// Options  : RB_ARB_TIMEOUT_EN - when defined, an access that sees no
//            bank_ack within TIMEOUT cycles completes with err = 1, rdata = 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter #(
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // port 0
  input  logic              req0_valid_i,
  input  logic              req0_wr_rdn_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [REG_W-1:0]  req0_wdata_i,
  output logic              req0_gnt_o,
  output logic              req0_done_o,
  output logic [REG_W-1:0]  req0_rdata_o,
  output logic              req0_err_o,
  // port 1
  input  logic              req1_valid_i,
  input  logic              req1_wr_rdn_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [REG_W-1:0]  req1_wdata_i,
  output logic              req1_gnt_o,
  output logic              req1_done_o,
  output logic [REG_W-1:0]  req1_rdata_o,
  output logic              req1_err_o,
  // bank side
  output logic              bank_ena_o,
  output logic              bank_wr_rdn_o,
  output logic [ADDR_W-1:0] bank_addr_o,
  output logic [REG_W-1:0]  bank_wdata_o,
  output logic              bank_we_o,
  input  logic [REG_W-1:0]  bank_rdata_i,
  input  logic              bank_ack_i,
  input  logic              bank_err_i
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_ACCESS = 2'd1;
  localparam logic [1:0] C_RESP   = 2'd2;

  // Reject an out-of-range timeout at elaboration; the counter is 8 bits.
  generate
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
      $error("reg_bank_arbiter: TIMEOUT must be in 1..255");
    end
  endgenerate

  logic [1:0]        state_q, state_d;

  // Captured request
  logic              wr_rdn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [REG_W-1:0]  wdata_q;
  logic              port_q;       // port owning the in-flight access
  logic              last_grant_q; // port granted at the most recent handshake

  // Per-port response registers; each port keeps its last response.
  logic [REG_W-1:0]  rdata0_q, rdata1_q;
  logic              err0_q,   err1_q;

  logic              w_gnt0, w_gnt1, w_hs;
  logic              w_timeout;
  logic              w_access_end;

  // --------------------------------------------------------------------------
  // Arbitration: a lone requester wins; under contention the port that was
  // not granted last wins. Grants are only possible in IDLE and never in reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if ((state_q == C_IDLE) && !rst) begin
      w_gnt0 = req0_valid_i && (!req1_valid_i ||  last_grant_q);
      w_gnt1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
    end
  end

  assign w_hs = w_gnt0 | w_gnt1;

  // --------------------------------------------------------------------------
  // Optional no-ack timeout
  // --------------------------------------------------------------------------
`ifdef RB_ARB_TIMEOUT_EN
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] to_cnt_q;

  // Counter value k means this is ACCESS cycle k+1, so the last allowed
  // cycle is the one where the count equals TIMEOUT-1. An ack in that same
  // cycle wins because w_timeout is qualified by !bank_ack_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= 8'd0;
    end else if (w_hs) begin
      to_cnt_q <= 8'd0;
    end else if ((state_q == C_ACCESS) && !bank_ack_i) begin
      to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  assign w_timeout = (state_q == C_ACCESS) && !bank_ack_i && (to_cnt_q == C_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_access_end = (state_q == C_ACCESS) && (bank_ack_i || w_timeout);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:   if (w_hs)         state_d = C_ACCESS;
      C_ACCESS: if (w_access_end) state_d = C_RESP;
      C_RESP:                     state_d = C_IDLE;
      default:                    state_d = C_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req0_gnt_o  = w_gnt0;
    req1_gnt_o  = w_gnt1;
    bank_ena_o  = (state_q == C_ACCESS);
    bank_we_o   = (state_q == C_ACCESS) && wr_rdn_q;
    req0_done_o = (state_q == C_RESP) && !port_q && !rst;
    req1_done_o = (state_q == C_RESP) &&  port_q && !rst;
  end

  // Bank request fields hold the last captured request outside ACCESS.
  assign bank_wr_rdn_o = wr_rdn_q;
  assign bank_addr_o   = addr_q;
  assign bank_wdata_o  = wdata_q;

  assign req0_rdata_o = rdata0_q;
  assign req0_err_o   = err0_q;
  assign req1_rdata_o = rdata1_q;
  assign req1_err_o   = err1_q;

  // --------------------------------------------------------------------------
  // Request capture and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_rdn_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      if (w_hs) begin
        wr_rdn_q     <= w_gnt1 ? req1_wr_rdn_i : req0_wr_rdn_i;
        addr_q       <= w_gnt1 ? req1_addr_i   : req0_addr_i;
        wdata_q      <= w_gnt1 ? req1_wdata_i  : req0_wdata_i;
        port_q       <= w_gnt1;
        last_grant_q <= w_gnt1;
      end
      // The response lands in the owning port's registers on the last
      // ACCESS cycle, so it is already visible when done pulses in RESP.
      if (w_access_end) begin
        if (!port_q) begin
          rdata0_q <= (bank_ack_i && !wr_rdn_q) ? bank_rdata_i : '0;
          err0_q   <= bank_ack_i ? bank_err_i : 1'b1;
        end else begin
          rdata1_q <= (bank_ack_i && !wr_rdn_q) ? bank_rdata_i : '0;
          err1_q   <= bank_ack_i ? bank_err_i : 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
// Module   : tb_reg_bank_arbiter
// Purpose  : Directed self-checking bench for reg_bank_arbiter with a small
//            behavioural register bank whose ack and err are bench-controlled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_wr_rdn, req0_gnt, req0_done, req0_err;
  logic [7:0] req0_addr, req0_wdata, req0_rdata;
  logic       req1_valid, req1_wr_rdn, req1_gnt, req1_done, req1_err;
  logic [7:0] req1_addr, req1_wdata, req1_rdata;
  logic       bank_ena, bank_wr_rdn, bank_we, bank_ack, bank_err;
  logic [7:0] bank_addr, bank_wdata, bank_rdata;

  int checks = 0;
  int errors = 0;

  // Bank model
  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bank_we && bank_ack) mem[bank_addr] <= bank_wdata;
  end
  assign bank_rdata = mem[bank_addr];

  always #5 clk = ~clk;

  reg_bank_arbiter #(.REG_W(8), .ADDR_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req0_wr_rdn_i(req0_wr_rdn), .req0_addr_i(req0_addr),
    .req0_wdata_i(req0_wdata), .req0_gnt_o(req0_gnt), .req0_done_o(req0_done),
    .req0_rdata_o(req0_rdata), .req0_err_o(req0_err),
    .req1_valid_i(req1_valid), .req1_wr_rdn_i(req1_wr_rdn), .req1_addr_i(req1_addr),
    .req1_wdata_i(req1_wdata), .req1_gnt_o(req1_gnt), .req1_done_o(req1_done),
    .req1_rdata_o(req1_rdata), .req1_err_o(req1_err),
    .bank_ena_o(bank_ena), .bank_wr_rdn_o(bank_wr_rdn), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_we_o(bank_we), .bank_rdata_i(bank_rdata),
    .bank_ack_i(bank_ack), .bank_err_i(bank_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({req0_gnt, req1_gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got %b want 00", {req0_gnt, req1_gnt});
    end
    checks++;
    if ({bank_ena, bank_we, req0_done, req1_done, req0_err, req1_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 000000",
                         {bank_ena, bank_we, req0_done, req1_done, req0_err, req1_err});
    end
    checks++;
    if ({req0_rdata, req1_rdata, bank_addr, bank_wdata, bank_wr_rdn} !== 33'b0) begin
      errors++; $display("FAIL reset_data got %h want 0",
                         {req0_rdata, req1_rdata, bank_addr, bank_wdata, bank_wr_rdn});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  // Both ports contend continuously right after reset: 0,1,0,1.
  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    rst = 1'b1; bank_ack = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_wr_rdn = 1'b0; req0_addr = 8'h10;
    req1_valid = 1'b1; req1_wr_rdn = 1'b0; req1_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({req0_gnt, req1_gnt} !== exp_g[i]) begin
        errors++; $display("FAIL rr_gnt[%0d] got %b want %b", i, {req0_gnt, req1_gnt}, exp_g[i]);
      end
      tick(); #1;
      checks++;
      if ({req0_gnt, req1_gnt} !== 2'b00) begin
        errors++; $display("FAIL rr_nogrant_access[%0d] got %b want 00", i, {req0_gnt, req1_gnt});
      end
      tick(); #1;
      checks++;
      if ({req0_done, req1_done} !== exp_g[i]) begin
        errors++; $display("FAIL rr_done[%0d] got %b want %b", i, {req0_done, req1_done}, exp_g[i]);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_write_read();
    bank_ack = 1'b1; bank_err = 1'b0;
    req0_valid = 1'b1; req0_wr_rdn = 1'b1; req0_addr = 8'h03; req0_wdata = 8'hA5;
    #1;
    checks++;
    if ({req0_gnt, req1_gnt} !== 2'b10) begin
      errors++; $display("FAIL wr_gnt got %b want 10", {req0_gnt, req1_gnt});
    end
    tick();
    req0_valid = 1'b0; #1;
    checks++;
    if ({bank_ena, bank_we, bank_wr_rdn, bank_addr, bank_wdata, req0_done} !== {3'b111, 8'h03, 8'hA5, 1'b0}) begin
      errors++; $display("FAIL wr_bank got %b/%h/%h want 111/03/a5",
                         {bank_ena, bank_we, bank_wr_rdn}, bank_addr, bank_wdata);
    end
    tick(); #1;
    checks++;
    if ({req0_done, req0_err, req0_rdata, bank_ena, bank_we} !== {2'b10, 8'h00, 2'b00}) begin
      errors++; $display("FAIL wr_done got %b/%h want 10/00 ena,we 00",
                         {req0_done, req0_err}, req0_rdata);
    end
    tick();
    req1_valid = 1'b1; req1_wr_rdn = 1'b0; req1_addr = 8'h03; #1;
    checks++;
    if ({req0_gnt, req1_gnt, req0_done} !== 3'b010) begin
      errors++; $display("FAIL rd_gnt got %b want 010", {req0_gnt, req1_gnt, req0_done});
    end
    tick();
    req1_valid = 1'b0; #1;
    checks++;
    if ({bank_ena, bank_we} !== 2'b10) begin
      errors++; $display("FAIL rd_bank got %b want 10", {bank_ena, bank_we});
    end
    tick(); #1;
    checks++;
    if ({req1_done, req1_err, req1_rdata} !== {2'b10, 8'hA5}) begin
      errors++; $display("FAIL rd_data got %b/%h want 10/a5", {req1_done, req1_err}, req1_rdata);
    end
    tick();
  endtask

  // Ack held low 5 cycles, then ack with bank_err set on the 6th.
  task automatic test_stall();
    int ena_cnt;
    preload(8'h81, 8'h3C);
    bank_ack = 1'b0; bank_err = 1'b0;
    req0_valid = 1'b1; req0_wr_rdn = 1'b0; req0_addr = 8'h81;
    tick();
    req0_valid = 1'b0;
    ena_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin bank_ack = 1'b1; bank_err = 1'b1; end
      #1;
      if (bank_ena) ena_cnt++;
      checks++;
      if (req0_done !== 1'b0) begin
        errors++; $display("FAIL stall_early_done[%0d] got %b want 0", i, req0_done);
      end
      tick();
    end
    bank_err = 1'b0; #1;
    checks++;
    if (ena_cnt !== 6) begin
      errors++; $display("FAIL stall_ena_cycles got %0d want 6", ena_cnt);
    end
    checks++;
    if ({req0_done, req0_err, req0_rdata, bank_ena} !== {2'b11, 8'h3C, 1'b0}) begin
      errors++; $display("FAIL stall_resp got %b/%h ena %b want 11/3c ena 0",
                         {req0_done, req0_err}, req0_rdata, bank_ena);
    end
    tick();
  endtask

  task automatic test_reset_access();
    bank_ack = 1'b0;
    req0_valid = 1'b1; req0_wr_rdn = 1'b0; req0_addr = 8'h81;
    tick();
    req0_valid = 1'b0; #1;
    checks++;
    if (bank_ena !== 1'b1) begin
      errors++; $display("FAIL rstacc_ena got %b want 1", bank_ena);
    end
    rst = 1'b1;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++;
    if ({bank_ena, req0_done, req1_done, req0_gnt, req1_gnt, req0_err, req0_rdata} !== 13'b0) begin
      errors++; $display("FAIL rstacc_clear got %b/%h want 0",
                         {bank_ena, req0_done, req1_done, req0_gnt, req1_gnt, req0_err}, req0_rdata);
    end
    tick();
    rst = 1'b0; #1;
    checks++;
    if ({req0_gnt, req1_gnt} !== 2'b10) begin
      errors++; $display("FAIL rstacc_regrant got %b want 10", {req0_gnt, req1_gnt});
    end
    bank_ack = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); #1;
    checks++;
    if ({req0_done, req1_done} !== 2'b10) begin
      errors++; $display("FAIL rstacc_done got %b want 10", {req0_done, req1_done});
    end
    tick();
  endtask

  task automatic test_hold();
    preload(8'h40, 8'h5A);
    preload(8'h41, 8'h11);
    bank_ack = 1'b1;
    req1_valid = 1'b1; req1_wr_rdn = 1'b0; req1_addr = 8'h40;
    tick();
    req1_valid = 1'b0;
    tick(); #1;
    checks++;
    if ({req1_done, req1_rdata} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL hold_p1 got %b/%h want 1/5a", req1_done, req1_rdata);
    end
    tick();
    req0_valid = 1'b1; req0_wr_rdn = 1'b0; req0_addr = 8'h41;
    tick();
    req0_valid = 1'b0;
    tick(); #1;
    checks++;
    if ({req0_done, req1_done, req0_rdata, req1_rdata} !== {2'b10, 8'h11, 8'h5A}) begin
      errors++; $display("FAIL hold_p0 got %b/%h/%h want 10/11/5a",
                         {req0_done, req1_done}, req0_rdata, req1_rdata);
    end
    tick(); #1;
    checks++;
    if ({req0_done, req1_rdata} !== {1'b0, 8'h5A}) begin
      errors++; $display("FAIL hold_after got %b/%h want 0/5a", req0_done, req1_rdata);
    end
  endtask

`ifdef RB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int run = 0; run < 2; run++) begin
      bank_ack = 1'b0;
      req0_valid = 1'b1; req0_wr_rdn = 1'b0; req0_addr = 8'h81;
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if ((run == 1) && (i == 3)) bank_ack = 1'b1;
        #1;
        checks++;
        if ({bank_ena, req0_done} !== 2'b10) begin
          errors++; $display("FAIL to_access[%0d][%0d] got %b want 10", run, i, {bank_ena, req0_done});
        end
        tick();
      end
      #1;
      checks++;
      if (run == 0) begin
        if ({req0_done, req0_err, req0_rdata} !== {2'b11, 8'h00}) begin
          errors++; $display("FAIL to_expire got %b/%h want 11/00", {req0_done, req0_err}, req0_rdata);
        end
      end else begin
        if ({req0_done, req0_err, req0_rdata} !== {2'b10, 8'h3C}) begin
          errors++; $display("FAIL to_ack_last got %b/%h want 10/3c", {req0_done, req0_err}, req0_rdata);
        end
      end
      bank_ack = 1'b1;
      tick();
    end
  endtask
`endif

  initial begin
    rst = 1'b1; bank_ack = 1'b0; bank_err = 1'b0;
    req0_valid = 1'b0; req0_wr_rdn = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_wr_rdn = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
    test_reset();
    test_contention();
    test_write_read();
    test_stall();
    test_reset_access();
    test_hold();
`ifdef RB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Two-port arbiter and sequencer for the register bank application interface (ena/wr_rdn/addr/wdata/we/rdata/ack/err).
- Lets two masters share one bank through a round-robin grant and a small FSM that issues each access and returns the read data and error status. Example masters: the SPI target and an on-chip debug/test controller.
- Sits between the masters and the bank; the bank's config/status arrays are untouched.

Parameters:
- REG_W, 8: data width of bank registers.
- ADDR_W, 8: bank address width; MSB selects config (0) or status (1).
- TIMEOUT, 15: ACCESS cycles waited for bank_ack before an error response; used only with RB_ARB_TIMEOUT_EN; must be 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  port 0 access request.
- req0_wr_rdn  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  REG_W  port 0 write data.
- req0_gnt  out  1  port 0 request accepted this cycle (combinational).
- req0_done  out  1  port 0 access complete, one-cycle pulse.
- req0_rdata  out  REG_W  port 0 read data, valid with done.
- req0_err  out  1  port 0 error, valid with done.
- req1_valid, req1_wr_rdn, req1_addr, req1_wdata, req1_gnt, req1_done, req1_rdata, req1_err: same as port 0, for port 1.
- bank_ena  out  1  bank access enable.
- bank_wr_rdn  out  1  direction to bank.
- bank_addr  out  ADDR_W  address to bank.
- bank_wdata  out  REG_W  write data to bank.
- bank_we  out  1  bank write enable.
- bank_rdata  in  REG_W  bank read data.
- bank_ack  in  1  bank handshake acknowledge.
- bank_err  in  1  bank error, qualified by bank_ack.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All registers, including the request capture and response registers, clear on reset.

IDLE:
- If any reqN_valid is high: assert the winner's reqN_gnt combinationally, capture its wr_rdn/addr/wdata into internal registers, go to ACCESS.
- The handshake is reqN_valid & reqN_gnt in the same cycle. The requester drops valid, or presents a new request, after the grant.

Arbitration:
- One valid: that port wins.
- Both valid: the port not equal to last_grant wins.
- last_grant updates at the handshake; reset value is 1, so port 0 wins the first contention.
- Never grant both ports in one cycle.
- No grant in ACCESS or RESP.

ACCESS:
- bank_ena = 1; bank_wr_rdn, bank_addr and bank_wdata driven from the capture registers; bank_we = captured wr_rdn.
- Held until a cycle with bank_ack = 1. In that cycle, capture bank_rdata (forced to 0 for writes) and bank_err into the response registers, then go to RESP.
- Repeated bank_we cycles rewrite the same data, so the write is idempotent.

RESP:
- Assert done for exactly one cycle on the granted port, with the response on reqN_rdata/reqN_err.
- Next state is IDLE.

Output holds:
- reqN_rdata/reqN_err hold their value until that port's next done. They are not cleared by the other port's traffic.
- The non-granted port's done stays 0.

Outputs outside ACCESS:
- bank_ena = bank_we = 0; bank_addr/bank_wdata/bank_wr_rdn hold the last captured values.

Latency:
- With bank_ack tied to 1: handshake at cycle N, bank_ena/bank_we at N+1, done at N+2.
- Throughput: one access per 3 cycles.

Reset:
- rst in any state returns the FSM to IDLE next cycle. The in-flight access is dropped with no done; all outputs go to 0 and last_grant goes to 1.

Reset values:
- All outputs 0.
- reqN_gnt is 0 while rst is high.

Optional Feature:
- Macro: RB_ARB_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without bank_ack.
  - When the count reaches TIMEOUT with no ack, go to RESP with rdata = 0 and err = 1.
  - An ack arriving in the same cycle as the timeout takes priority, giving a normal response.
- Not defined: no counter; ACCESS waits indefinitely for bank_ack.

Test Plan:
- Port 0 write addr 0x03, wdata 0xA5, bank_ack = 1: one bank_we pulse with addr 0x03/0xA5 at N+1, req0_done at N+2 with err = 0. A following port 1 read of 0x03 returns 0xA5.
- Both ports valid at the same time right after reset: port 0 granted first, port 1 granted at the next IDLE; ports alternate 0,1,0,1 over 4 back-to-back accesses.
- bank_ack held low for 5 cycles during a read of 0x81: bank_ena held 6 cycles; done arrives 1 cycle after ack with the captured bank_rdata (e.g. 0x3C).
- rst asserted in ACCESS: no done on either port; bank_ena = 0 next cycle. The next contended request grants port 0.
- Port 1 done with rdata 0x5A, then port 0 access completes: req1_rdata stays 0x5A.
- With RB_ARB_TIMEOUT_EN and TIMEOUT = 4, bank_ack tied low: done with err = 1 and rdata = 0 after 4 ACCESS cycles. A second run where ack arrives on the 4th cycle gives err = 0 and real data.
